mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_arb2.sv | 20 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
//   state_e : arbiter FSM states (IDLE / ACCESS / RESPOND)
//   owner_e : which requester owns the access in flight
//   DEF_*   : default bus widths and access timeout
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-request round-robin grant, purely combinational.
//   cpu_req_i, dma_req_i : live requests
//   last_i               : requester served most recently
//   win_o                : granted requester (only meaningful if a request is up)
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   dma_req_i,
  input  owner_e last_i,
  output owner_e win_o
);

  // DMA wins when it is alone, or on a tie when CPU went last.
  always_comb begin
    win_o = OWN_CPU;
    if (dma_req_i && (!cpu_req_i || last_i == OWN_CPU)) win_o = OWN_DMA;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between a CPU and a DMA requester.
// One access in flight at a time; round-robin on ties; access timeout sets err.
//   clk, reset_n                    : clock, async active-low reset
//   cpu_* / dma_*                   : requester ports (req/we/addr/wdata in, ack/rdata out)
//   mem_en/we/addr/wdata            : memory request, driven while in ACCESS
//   mem_rdata, mem_ready            : memory response, looked at only in ACCESS
//   err                             : timeout flag, valid with the ack, held until next ack
//   cpu_stall                       : cpu_req & ~cpu_ack
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err,
  output logic              cpu_stall
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q,  last_d;
  owner_e            win;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              err_q,   err_d;
  logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0] dma_rd_q, dma_rd_d;

  rr_arb2 u_arb (
    .cpu_req_i (cpu_req),
    .dma_req_i (dma_req),
    .last_i    (last_q),
    .win_o     (win)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    cpu_rd_d = cpu_rd_q;
    dma_rd_d = dma_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d = win;
          we_d    = (win == OWN_DMA) ? dma_we    : cpu_we;
          addr_d  = (win == OWN_DMA) ? dma_addr  : cpu_addr;
          wdata_d = (win == OWN_DMA) ? dma_wdata : cpu_wdata;
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          if (!we_q) begin
            if (owner_q == OWN_DMA) dma_rd_d = mem_rdata;
            else                    cpu_rd_d = mem_rdata;
          end
          err_d   = 1'b0;
          state_d = ST_RESPOND;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          // This is the MAX_WAIT-th cycle without ready: give up, keep rdata.
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESPOND: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_CPU;
      last_q   <= OWN_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      cpu_rd_q <= '0;
      dma_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      cpu_rd_q <= cpu_rd_d;
      dma_rd_q <= dma_rd_d;
    end
  end

  // Outputs decode from registered state so reset drops them without an edge.
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = (state_q == ST_RESPOND) && (owner_q == OWN_CPU);
  assign dma_ack   = (state_q == ST_RESPOND) && (owner_q == OWN_DMA);
  assign cpu_rdata = cpu_rd_q;
  assign dma_rdata = dma_rd_q;
  assign err       = err_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-timeline model predicts every output,
// a negedge process compares them, directed tests add literal expectations.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          cpu_ack, dma_ack, mem_en, mem_we, err, cpu_stall;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err), .cpu_stall(cpu_stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a granted transaction occupies cycles t=1..m_tot on the memory
  // and cycle t=m_tot+1 is its ack cycle.
  bit            m_busy, m_dma, m_we, m_tout, m_last_dma, m_err;
  int            m_t, m_tot;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_cpu_rd, m_dma_rd;
  int            mem_wait = 0;     // ready after this many wait cycles
  bit            ready_noise = 1'b0;
  bit            cmp_on = 1'b0;
  int            we_cyc = 0;

  function automatic bit exp_en();
    return m_busy && (m_t <= m_tot);
  endfunction

  function automatic bit exp_ack();
    return m_busy && (m_t == m_tot + 1);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_dma = 0; m_we = 0; m_tout = 0; m_last_dma = 0; m_err = 0;
    m_t = 0; m_tot = 0; m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dma_rd = '0;
  endtask

  task automatic tick();
    bit sc, sd, scw, sdw;
    logic [AW-1:0] sca, sda;
    logic [DW-1:0] scd, sdd;
    sc = cpu_req; sd = dma_req; scw = cpu_we; sdw = dma_we;
    sca = cpu_addr; sda = dma_addr; scd = cpu_wdata; sdd = dma_wdata;
    @(posedge clk);
    #1;
    if (!reset_n) model_reset();
    else if (m_busy) begin
      if (exp_ack()) begin
        m_busy = 0;
        m_last_dma = m_dma;
        if (m_dma) dma_req = 1'b0; else cpu_req = 1'b0;
      end else begin
        m_t++;
        if (m_t == m_tot + 1) begin
          m_err = m_tout;
          if (!m_tout && !m_we) begin
            if (m_dma) m_dma_rd = mem_rdata; else m_cpu_rd = mem_rdata;
          end
        end
      end
    end else if (sc || sd) begin
      m_dma   = sd && (!sc || !m_last_dma);
      m_we    = m_dma ? sdw : scw;
      m_addr  = m_dma ? sda : sca;
      m_wdata = m_dma ? sdd : scd;
      m_busy  = 1; m_t = 1;
      m_tout  = (mem_wait >= MW);
      m_tot   = m_tout ? MW : mem_wait + 1;
    end
    mem_ready = exp_en() ? (m_t - 1 == mem_wait) : ready_noise;
  endtask

  always @(negedge clk) begin
    if (cmp_on && reset_n) begin
      bit en, ack;
      en = exp_en();
      ack = exp_ack();
      chk("mem_en", mem_en, en);
      chk("mem_we", mem_we, en && m_we);
      if (en) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (mem_en && mem_we) we_cyc++;
      chk("cpu_ack", cpu_ack, ack && !m_dma);
      chk("dma_ack", dma_ack, ack && m_dma);
      chk("err", err, m_err);
      chk("cpu_rdata", cpu_rdata, m_cpu_rd);
      chk("dma_rdata", dma_rdata, m_dma_rd);
      chk("cpu_stall", cpu_stall, cpu_req && !(ack && !m_dma));
    end
  end

  task automatic wait_ack(input string nm, input int exp_lat, input bit exp_dma);
    int lat;
    bit got;
    lat = 0; got = 0;
    while (!got && lat < 60) begin
      tick();
      lat++;
      if (cpu_ack || dma_ack) got = 1;
    end
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_who"}, dma_ack, exp_dma);
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_acks", {cpu_ack, dma_ack}, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    reset_n = 1'b1;
    cmp_on = 1'b1;
    tick();

    // CPU read, ready on first access cycle
    mem_wait = 0; mem_rdata = 32'hDEADBEEF;
    cpu_addr = 32'h100; cpu_we = 1'b0; cpu_req = 1'b1;
    wait_ack("cpu_rd", 2, 0);
    chk("cpu_rd_err", err, 0);
    tick();
    chk("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);

    // Ties from reset: DMA, CPU, DMA, CPU
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    cpu_addr = 32'h200; dma_addr = 32'h300; dma_we = 1'b0;
    mem_rdata = 32'h1111_0001; cpu_req = 1'b1; dma_req = 1'b1;
    wait_ack("tie1", 2, 1);
    tick();
    mem_rdata = 32'h2222_0002;
    wait_ack("tie2", 2, 0);
    tick();
    mem_rdata = 32'h3333_0003; cpu_req = 1'b1; dma_req = 1'b1;
    wait_ack("tie3", 2, 1);
    tick();
    mem_rdata = 32'h4444_0004;
    wait_ack("tie4", 2, 0);
    tick();
    chk("tie_cpu_rd", cpu_rdata, 32'h4444_0004);
    chk("tie_dma_rd", dma_rdata, 32'h3333_0003);

    // DMA write with 3 wait cycles
    mem_wait = 3; we_cyc = 0; mem_rdata = 32'h5555_5555;
    dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h12345678; dma_req = 1'b1;
    wait_ack("dma_wr", 5, 1);
    chk("dma_wr_we_cycles", we_cyc, 4);
    chk("dma_wr_rd_kept", dma_rdata, 32'h3333_0003);
    tick();
    dma_we = 1'b0;

    // Timeout with stray mem_ready outside ACCESS, then recovery
    mem_wait = 100; ready_noise = 1'b1; mem_rdata = 32'hBAD0BAD0;
    cpu_addr = 32'h500; cpu_req = 1'b1;
    wait_ack("tout", 17, 0);
    chk("tout_err", err, 1);
    tick();
    chk("tout_err_hold", err, 1);
    chk("tout_rd_kept", cpu_rdata, 32'h4444_0004);
    mem_wait = 1; ready_noise = 1'b0; mem_rdata = 32'hC0FFEE00; cpu_req = 1'b1;
    wait_ack("good", 3, 0);
    chk("good_err", err, 0);
    tick();
    chk("good_rd", cpu_rdata, 32'hC0FFEE00);

    // Reset in the middle of ACCESS
    mem_wait = 100; cpu_addr = 32'h600; cpu_req = 1'b1;
    repeat (3) tick();
    chk("pre_rst_mem_en", mem_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_mem_en", mem_en, 0);
    chk("async_ack", cpu_ack, 0);
    tick();
    reset_n = 1'b1;
    mem_wait = 0; mem_rdata = 32'h600D600D;
    wait_ack("post_rst", 2, 0);
    tick();
    chk("post_rst_rd", cpu_rdata, 32'h600D600D);

    // cpu_stall and cpu_rdata survive a DMA read
    mem_rdata = 32'h0000CAFE; cpu_addr = 32'h700; cpu_req = 1'b1;
    tick();
    chk("stall_access", cpu_stall, 1);
    wait_ack("cpu6", 1, 0);
    chk("stall_ack", cpu_stall, 0);
    tick();
    mem_rdata = 32'h0000F00D; dma_addr = 32'h800; dma_req = 1'b1;
    wait_ack("dma6", 2, 1);
    tick();
    chk("cpu6_rd_kept", cpu_rdata, 32'h0000CAFE);
    chk("dma6_rd", dma_rdata, 32'h0000F00D);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
